adc_dac_sequencer: RTL and testbench
====================================

Name: adc_dac_sequencer

Overview:
- Multi-channel successor to the single-channel tick-driven ADC->DAC loop. Generates its own sample tick and runs one frame per tick.
- For each channel 0..NUM_CHANNELS-1 in turn, a frame starts the ADC reader, waits for the result, applies a per-channel mode transform, then starts the DAC writer and waits for it to finish.
- Sits between the top-level pin wiring and the existing AdcReader/DacWriter, replacing the fixed TickGen start path. Adds overrun detection and frame counting.

Parameters:
- DATA_W, 16, sample width (two's complement) for ADC in and DAC out.
- NUM_CHANNELS, 2, channels per frame (1..16).
- DIVIDER, 50, clk_i cycles between frame ticks (>=2).
- CH_W, derived = max(1, $clog2(NUM_CHANNELS)), channel index width.

Ports:
- clk_i  in  1  system clock.
- reset_ni  in  1  synchronous reset, active-low.
- enable_i  in  1  run (1) / pause (0).
- channel_mode_i  in  2*NUM_CHANNELS  per-channel mode; bits [2c+1:2c] apply to channel c.
- adc_start_o  out  1  one-cycle start pulse to the ADC reader.
- adc_channel_o  out  CH_W  channel being converted.
- adc_idle_i  in  1  ADC reader is_idle.
- adc_data_i  in  DATA_W  ADC result; valid when adc_idle_i returns high.
- dac_start_o  out  1  one-cycle start pulse to the DAC writer.
- dac_channel_o  out  CH_W  DAC channel address.
- dac_data_o  out  DATA_W  processed sample.
- dac_idle_i  in  1  DAC writer is_idle.
- busy_o  out  1  high whenever state != IDLE.
- overrun_o  out  1  sticky: a tick arrived while a frame was in progress.
- frame_count_o  out  16  completed frames, wraps at 16 bits.

Behaviour:
- Reset (reset_ni=0 at a clk_i edge) forces:
  - all outputs to 0 and state to IDLE;
  - divider counter, channel index, overrun_o and frame_count_o to 0.
  - Reset takes effect mid-frame and abandons the frame; no further start pulses are issued.
- Divider:
  - When enable_i=1, the counter counts 0..DIVIDER-1 and wraps. tick=1 in the cycle the counter equals DIVIDER-1.
  - When enable_i=0, the counter is held at 0 and no ticks occur. A frame already in progress still completes.
- FSM (Moore; all outputs registered):
  - IDLE: on tick, channel index <= 0, go to ADC_START.
  - ADC_START: adc_start_o=1 for exactly this cycle; adc_channel_o = index. Go to ADC_WAIT.
  - ADC_WAIT: first wait until adc_idle_i=0 has been seen (seen flag), then until adc_idle_i=1. At that point capture adc_data_i and go to PROCESS.
  - PROCESS: compute the transform into dac_data_o and set dac_channel_o = index. Go to DAC_START.
  - DAC_START: dac_start_o=1 for exactly this cycle. Go to DAC_WAIT.
  - DAC_WAIT: same seen-low-then-high rule on dac_idle_i. Then, if index == NUM_CHANNELS-1, increment frame_count_o and go to IDLE; otherwise increment index and go to ADC_START.
- Latency: when the tick occurs in cycle T, adc_start_o is high in cycle T+1. dac_start_o is high exactly 2 cycles after the ADC_WAIT exit cycle.
- Mode transform (per channel):
  - 00: pass, x.
  - 01: invert, -x, saturated: the most negative value (-2^(DATA_W-1)) maps to 2^(DATA_W-1)-1.
  - 10: halve, arithmetic shift right by 1 (-1 -> -1, -3 -> -2).
  - 11: mute, 0.
  - channel_mode_i is sampled in PROCESS.
- dac_data_o and dac_channel_o hold their values until the next PROCESS. adc_channel_o holds until the next ADC_START.
- Overrun: a tick in any state other than IDLE sets overrun_o=1 and is dropped; the frame is not restarted. overrun_o clears only on reset.
- The tick and the last DAC_WAIT exit can fall in the same cycle; the tick is then seen in DAC_WAIT, so overrun_o is set and the FSM goes to IDLE without starting a new frame.
- busy_o = (state != IDLE).

Test Plan:
- NUM_CHANNELS=2, DIVIDER=50, modes=00/00, ADC model returns 16'h1234 then 16'h8000 after 20 cycles busy; DAC model is busy 20 cycles -> dac_data_o=16'h1234 on ch0, 16'h8000 on ch1, frame_count_o=1, adc_start_o exactly at T+1.
- Modes ch0=01, ch1=10; ADC returns -32768 then -3 -> DAC gets 32767 on ch0 and -2 on ch1; mode 11 with ADC 16'h7FFF -> DAC gets 0.
- DIVIDER=50 with ADC busy 40 cycles per channel -> second tick lands mid-frame, overrun_o=1 and stays 1; frame_count_o still increments once per completed frame.
- enable_i dropped during ch0's ADC_WAIT -> the frame completes with both DAC writes, then there are no adc_start_o pulses for 200 cycles; re-raising enable_i gives the first tick after exactly 50 cycles.
- reset_ni pulsed low for 1 cycle during DAC_WAIT -> next cycle all outputs are 0 and state is IDLE; a new frame starts after the first full divider period.
- Idle handshakes delayed: adc_idle_i stays high for 3 cycles after adc_start_o before dropping -> FSM must not capture early; data is captured only after idle has gone low and then high again.

Source files
------------

// File: rtl/adc_dac_sequencer.sv
// adc_dac_sequencer: generates a frame tick and, once per tick, walks every
// channel through ADC conversion, a per-channel mode transform and a DAC write.
// Detects ticks that arrive mid-frame (overrun) and counts completed frames.
module adc_dac_sequencer #(
    parameter int DATA_W       = 16,
    parameter int NUM_CHANNELS = 2,
    parameter int DIVIDER      = 50,
    parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      enable_i,
    input  logic [2*NUM_CHANNELS-1:0] channel_mode_i,
    output logic                      adc_start_o,
    output logic [CH_W-1:0]           adc_channel_o,
    input  logic                      adc_idle_i,
    input  logic [DATA_W-1:0]         adc_data_i,
    output logic                      dac_start_o,
    output logic [CH_W-1:0]           dac_channel_o,
    output logic [DATA_W-1:0]         dac_data_o,
    input  logic                      dac_idle_i,
    output logic                      busy_o,
    output logic                      overrun_o,
    output logic [15:0]               frame_count_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADC_START = 3'd1,
        ST_ADC_WAIT  = 3'd2,
        ST_PROCESS   = 3'd3,
        ST_DAC_START = 3'd4,
        ST_DAC_WAIT  = 3'd5
    } state_e;

    localparam int              CNT_W    = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDER - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);

    // Mode transform: pass, saturating negate, arithmetic halve, mute.
    function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] x,
                                                 input logic [1:0]        mode);
        logic [DATA_W-1:0] min_v;
        min_v = {1'b1, {(DATA_W-1){1'b0}}};
        case (mode)
            2'b00:   xform = x;
            2'b01:   xform = (x == min_v) ? ~min_v : (~x + DATA_W'(1));
            2'b10:   xform = {x[DATA_W-1], x[DATA_W-1:1]};
            2'b11:   xform = {DATA_W{1'b0}};
            default: xform = {DATA_W{1'b0}};
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CH_W-1:0]     idx_q, idx_d;
    logic                seen_q, seen_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic                adc_start_q, adc_start_d;
    logic [CH_W-1:0]     adc_channel_q, adc_channel_d;
    logic                dac_start_q, dac_start_d;
    logic [CH_W-1:0]     dac_channel_q, dac_channel_d;
    logic [DATA_W-1:0]   dac_data_q, dac_data_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;
    logic [15:0]         frame_count_q, frame_count_d;
    logic                tick_s;
    logic [1:0]          mode_s;

    // Frame divider: free-runs while enabled, parked at zero while paused.
    always_comb begin
        tick_s = enable_i && (cnt_q == CNT_LAST);
        if (!enable_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Sequencer next state; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        seen_d        = seen_q;
        sample_d      = sample_q;
        adc_channel_d = adc_channel_q;
        dac_channel_d = dac_channel_q;
        dac_data_d    = dac_data_q;
        frame_count_d = frame_count_q;
        overrun_d     = overrun_q | (tick_s & (state_q != ST_IDLE));
        mode_s        = channel_mode_i[{idx_q, 1'b0} +: 2];

        case (state_q)
            ST_IDLE: begin
                if (tick_s) begin
                    idx_d   = {CH_W{1'b0}};
                    state_d = ST_ADC_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADC_START: begin
                seen_d  = 1'b0;
                state_d = ST_ADC_WAIT;
            end
            ST_ADC_WAIT: begin
                // The reader must be seen busy before its idle counts as "done".
                if (seen_q && adc_idle_i) begin
                    sample_d = adc_data_i;
                    state_d  = ST_PROCESS;
                end else if (!adc_idle_i) begin
                    seen_d = 1'b1;
                end else begin
                    seen_d = seen_q;
                end
            end
            ST_PROCESS: begin
                dac_data_d    = xform(sample_q, mode_s);
                dac_channel_d = idx_q;
                state_d       = ST_DAC_START;
            end
            ST_DAC_START: begin
                seen_d  = 1'b0;
                state_d = ST_DAC_WAIT;
            end
            ST_DAC_WAIT: begin
                if (seen_q && dac_idle_i) begin
                    if (idx_q == CH_LAST) begin
                        frame_count_d = frame_count_q + 16'd1;
                        state_d       = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + CH_W'(1);
                        state_d = ST_ADC_START;
                    end
                end else if (!dac_idle_i) begin
                    seen_d = 1'b1;
                end else begin
                    seen_d = seen_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        adc_start_d = (state_d == ST_ADC_START);
        dac_start_d = (state_d == ST_DAC_START);
        busy_d      = (state_d != ST_IDLE);
        if (state_d == ST_ADC_START) begin
            adc_channel_d = idx_d;
        end else begin
            adc_channel_d = adc_channel_q;
        end
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q       <= ST_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            idx_q         <= {CH_W{1'b0}};
            seen_q        <= 1'b0;
            sample_q      <= {DATA_W{1'b0}};
            adc_start_q   <= 1'b0;
            adc_channel_q <= {CH_W{1'b0}};
            dac_start_q   <= 1'b0;
            dac_channel_q <= {CH_W{1'b0}};
            dac_data_q    <= {DATA_W{1'b0}};
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            seen_q        <= seen_d;
            sample_q      <= sample_d;
            adc_start_q   <= adc_start_d;
            adc_channel_q <= adc_channel_d;
            dac_start_q   <= dac_start_d;
            dac_channel_q <= dac_channel_d;
            dac_data_q    <= dac_data_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign adc_start_o   = adc_start_q;
    assign adc_channel_o = adc_channel_q;
    assign dac_start_o   = dac_start_q;
    assign dac_channel_o = dac_channel_q;
    assign dac_data_o    = dac_data_q;
    assign busy_o        = busy_q;
    assign overrun_o     = overrun_q;
    assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_adc_dac_sequencer.sv
// Testbench for adc_dac_sequencer: ADC/DAC bus models, a sequential
// behavioural reference model, a per-cycle compare process, and directed plus
// randomized scenarios.
module tb_adc_dac_sequencer;

    localparam int DW  = 16;
    localparam int NCH = 2;
    localparam int DIV = 50;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  mode = 4'd0;
    logic        adc_idle = 1'b1;
    logic        dac_idle = 1'b1;
    logic [15:0] adc_data = 16'd0;

    logic        adc_start_o, dac_start_o, busy_o, overrun_o;
    logic        adc_channel_o, dac_channel_o;
    logic [15:0] dac_data_o, frame_count_o;

    always #5 clk = ~clk;

    adc_dac_sequencer #(.DATA_W(DW), .NUM_CHANNELS(NCH), .DIVIDER(DIV)) dut (
        .clk_i(clk), .reset_ni(reset_n), .enable_i(enable), .channel_mode_i(mode),
        .adc_start_o(adc_start_o), .adc_channel_o(adc_channel_o), .adc_idle_i(adc_idle),
        .adc_data_i(adc_data), .dac_start_o(dac_start_o), .dac_channel_o(dac_channel_o),
        .dac_data_o(dac_data_o), .dac_idle_i(dac_idle), .busy_o(busy_o),
        .overrun_o(overrun_o), .frame_count_o(frame_count_o)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- bus models ----------------
    int          adc_pre = 0, adc_busy = 20, dac_pre = 0, dac_busy = 20;
    bit          rnd_data = 1'b0;
    logic [15:0] adc_val [2];
    int          adc_ch;

    always begin
        @(negedge clk);
        if (adc_start_o === 1'b1) begin
            adc_ch   = int'(adc_channel_o);
            adc_data = 16'hDEAD;
            repeat (adc_pre) @(negedge clk);
            adc_idle = 1'b0;
            repeat (adc_busy) @(negedge clk);
            adc_data = rnd_data ? 16'($urandom) : adc_val[adc_ch];
            adc_idle = 1'b1;
        end
    end

    always begin
        @(negedge clk);
        if (dac_start_o === 1'b1) begin
            repeat (dac_pre) @(negedge clk);
            dac_idle = 1'b0;
            repeat (dac_busy) @(negedge clk);
            dac_idle = 1'b1;
        end
    end

    // ---------------- observation log ----------------
    bit          chk_on = 1'b0;
    bit          got_first = 1'b0;
    int          first_start = 0;
    int          n_adc_start = 0;
    logic [16:0] wlog [$];

    always @(negedge clk) begin
        if (chk_on) begin
            if (dac_start_o === 1'b1) wlog.push_back({dac_channel_o, dac_data_o});
            if (adc_start_o === 1'b1) begin
                n_adc_start++;
                if (!got_first) begin
                    got_first   = 1'b1;
                    first_start = cyc;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic        e_adc_start = 0, e_dac_start = 0, e_busy = 0, e_ovr = 0;
    logic        e_adc_ch = 0, e_dac_ch = 0;
    logic [15:0] e_dac_data = 0, e_fc = 0;
    int          m_cnt = 0;
    bit          m_abort, m_tick, m_seen;
    logic        m_adc_idle, m_dac_idle;
    logic [15:0] m_adc_data, m_x;
    logic [3:0]  m_mode;

    function automatic logic [15:0] ref_xform(input logic [15:0] x, input logic [1:0] md);
        int v;
        v = int'($signed(x));
        case (md)
            2'b00: return x;
            2'b01: begin
                v = -v;
                if (v > 32767) v = 32767;
                return 16'(v);
            end
            2'b10: return 16'((v < 0) ? -((-v + 1) / 2) : (v / 2));
            default: return 16'd0;
        endcase
    endfunction

    // One clock edge as the sequencer sees it: sample inputs, advance divider, note overrun.
    task automatic mstep();
        bit was_busy;
        @(posedge clk);
        was_busy    = e_busy;
        m_adc_idle  = adc_idle;
        m_dac_idle  = dac_idle;
        m_adc_data  = adc_data;
        m_mode      = mode;
        e_adc_start = 1'b0;
        e_dac_start = 1'b0;
        if (!reset_n) begin
            m_abort = 1'b1; m_tick = 1'b0; m_cnt = 0;
            e_busy = 0; e_ovr = 0; e_adc_ch = 0; e_dac_ch = 0; e_dac_data = 0; e_fc = 0;
        end else begin
            m_tick = enable && (m_cnt == DIV - 1);
            m_cnt  = enable ? (m_cnt + 1) % DIV : 0;
            if (m_tick && was_busy) e_ovr = 1'b1;
        end
    endtask

    // Frame script: wait for a tick while idle, then convert and write each channel.
    initial begin : model
        forever begin
            m_abort = 1'b0;
            mstep();
            if (m_abort || !m_tick) continue;
            for (int c = 0; c < NCH; c++) begin
                e_adc_start = 1'b1; e_adc_ch = 1'(c); e_busy = 1'b1;
                mstep(); if (m_abort) break;
                m_seen = 1'b0;
                forever begin
                    mstep(); if (m_abort) break;
                    if (m_seen && m_adc_idle) break;
                    if (!m_adc_idle) m_seen = 1'b1;
                end
                if (m_abort) break;
                m_x = m_adc_data;
                mstep(); if (m_abort) break;
                e_dac_data = ref_xform(m_x, m_mode[2*c +: 2]);
                e_dac_ch = 1'(c); e_dac_start = 1'b1;
                mstep(); if (m_abort) break;
                m_seen = 1'b0;
                forever begin
                    mstep(); if (m_abort) break;
                    if (m_seen && m_dac_idle) break;
                    if (!m_dac_idle) m_seen = 1'b1;
                end
                if (m_abort) break;
                if (c == NCH - 1) begin
                    e_fc++; e_busy = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("adc_start_o", adc_start_o, e_adc_start);
            chk("adc_channel_o", adc_channel_o, e_adc_ch);
            chk("dac_start_o", dac_start_o, e_dac_start);
            chk("dac_channel_o", dac_channel_o, e_dac_ch);
            chk("dac_data_o", dac_data_o, e_dac_data);
            chk("busy_o", busy_o, e_busy);
            chk("overrun_o", overrun_o, e_ovr);
            chk("frame_count_o", frame_count_o, e_fc);
        end
    end

    // ---------------- directed helpers ----------------
    int r_cyc = 0;

    task automatic do_reset();
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ovr", overrun_o, 1'b0);
        chk("rst_fc", frame_count_o, 16'd0);
        chk("rst_dac_data", dac_data_o, 16'd0);
        chk("rst_starts", {adc_start_o, dac_start_o}, 2'b00);
        reset_n = 1'b1;
        r_cyc = cyc;
        got_first = 1'b0;
        wlog.delete();
    endtask

    task automatic wait_fc(input logic [15:0] target);
        int n = 0;
        while (frame_count_o !== target && n < 400) begin @(negedge clk); n++; end
        chk("frame_done", frame_count_o, target);
    endtask

    task automatic wait_start();
        int n = 0;
        while (!got_first && n < 200) begin @(negedge clk); n++; end
        chk("start_seen", got_first, 1'b1);
    endtask

    task automatic chk_wlog(input int i, input logic [16:0] exp);
        chk("wlog_len", wlog.size() > i, 1'b1);
        if (wlog.size() > i) chk("dac_write", wlog[i], exp);
    endtask

    int e_cyc, n0;

    initial begin
        adc_val[0] = 16'h1234; adc_val[1] = 16'h8000;
        enable = 1'b1;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1; r_cyc = cyc; chk_on = 1'b1;

        // model pins
        chk("ref_inv_min", ref_xform(16'h8000, 2'b01), 16'h7FFF);
        chk("ref_half_m3", ref_xform(16'hFFFD, 2'b10), 16'hFFFE);
        chk("ref_half_m1", ref_xform(16'hFFFF, 2'b10), 16'hFFFF);

        // pass-through frame and start latency
        wait_start();
        chk("first_start_lat", first_start, r_cyc + 50);
        wait_fc(16'd1);
        chk_wlog(0, {1'b0, 16'h1234});
        chk_wlog(1, {1'b1, 16'h8000});

        // invert / halve, then mute
        mode = 4'b1001; adc_val[0] = 16'h8000; adc_val[1] = 16'hFFFD;
        do_reset();
        wait_fc(16'd1);
        chk_wlog(0, {1'b0, 16'h7FFF});
        chk_wlog(1, {1'b1, 16'hFFFE});
        mode = 4'b0011; adc_val[0] = 16'h7FFF;
        do_reset();
        wait_fc(16'd1);
        chk_wlog(0, {1'b0, 16'h0000});

        // long conversions: overrun sticks, frames still counted
        mode = 4'b0000; adc_busy = 40;
        do_reset();
        wait_fc(16'd1);
        chk("overrun_set", overrun_o, 1'b1);
        wait_fc(16'd2);
        chk("overrun_sticky", overrun_o, 1'b1);
        adc_busy = 20;

        // pause mid-frame
        do_reset();
        wait_start();
        repeat (5) @(negedge clk);
        enable = 1'b0;
        n0 = wlog.size();
        wait_fc(16'd1);
        chk("pause_writes", wlog.size() - n0, 2);
        n0 = n_adc_start;
        repeat (200) @(negedge clk);
        chk("paused_starts", n_adc_start - n0, 0);
        enable = 1'b1; e_cyc = cyc; got_first = 1'b0;
        wait_start();
        chk("resume_lat", first_start, e_cyc + 50);

        // reset during DAC_WAIT
        do_reset();
        begin
            int n = 0;
            while (dac_start_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
            chk("dac_start_seen", dac_start_o, 1'b1);
        end
        repeat (3) @(negedge clk);
        do_reset();
        wait_start();
        chk("post_rst_lat", first_start, r_cyc + 50);

        // idle held high after start: no early capture
        adc_pre = 3; adc_val[0] = 16'h0BEE;
        do_reset();
        wait_fc(16'd1);
        chk_wlog(0, {1'b0, 16'h0BEE});

        // randomized operation
        rnd_data = 1'b1;
        for (int it = 0; it < 40; it++) begin
            mode     = 4'($urandom);
            adc_busy = $urandom_range(1, 20);
            adc_pre  = $urandom_range(0, 3);
            dac_busy = $urandom_range(1, 20);
            dac_pre  = $urandom_range(0, 3);
            enable   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 7) == 0) do_reset();
            repeat ($urandom_range(20, 150)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
